// File: rtl/multiplier_pkg.sv
// Shared types and default parameters for the sequential shift-add multiplier.
package multiplier_pkg;

  // Default operand width and multiplier bits consumed per iteration
  localparam int N_DEFAULT = 8;
  localparam int K_DEFAULT = 1;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage : multiplier_pkg

// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned multiplier.
// Operands are converted to magnitudes on acceptance. The product is then built
// LSB-first, K multiplier bits per clock, and finally re-signed into p_out.
// N must be >= 2 and an integer multiple of K.
module seq_multiplier
  import multiplier_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int K = K_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           is_signed,
  input  logic [N-1:0]   data_a,
  input  logic [N-1:0]   data_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p_out,
  output logic           busy
);

  localparam int ITERS = N / K;
  localparam int CW    = $clog2(ITERS + 1);
  localparam int PW    = 2 * N;
  localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

  mul_state_e state, state_next;

  logic [PW-1:0] mcand;     // magnitude of a, pre-shifted to the current bit position
  logic [N-1:0]  mplier;    // remaining multiplier magnitude bits, consumed from the LSB
  logic [PW-1:0] acc;       // running product magnitude
  logic [CW-1:0] cnt;       // iterations completed in CALC
  logic          sign;      // product must be negated
  logic [PW-1:0] p_reg;     // presented product, held until the next completion

  logic          accept;
  logic          last_iter;
  logic [N-1:0]  mag_a;
  logic [N-1:0]  mag_b;
  logic [K-1:0]  chunk;
  logic [PW-1:0] partial;
  logic [PW-1:0] acc_sum;

  assign accept    = in_valid && (state == IDLE);
  assign last_iter = (cnt == LAST_CNT);

  // Magnitudes of the offered operands; the most negative value maps to 2^(N-1)
  always_comb begin
    mag_a = data_a;
    mag_b = data_b;
    if (is_signed && data_a[N-1]) mag_a = -data_a;
    if (is_signed && data_b[N-1]) mag_b = -data_b;
  end

  // One shift-add step: multiplicand times the next K multiplier bits
  always_comb begin
    chunk   = mplier[K-1:0];
    partial = mcand * PW'(chunk);
    acc_sum = acc + partial;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on acceptance, iterate in CALC, publish on the last step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      p_reg  <= '0;
    end else if (accept) begin
      mcand  <= {{N{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      cnt    <= '0;
      sign   <= is_signed && (data_a[N-1] ^ data_b[N-1]);
    end else if (state == CALC) begin
      acc    <= acc_sum;
      mcand  <= mcand << K;
      mplier <= mplier >> K;
      cnt    <= cnt + CW'(1);
      if (last_iter) begin
        p_reg <= sign ? -acc_sum : acc_sum;
      end
    end
  end

  assign p_out = p_reg;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases, backpressure,
// mid-operation reset, a K=4 build, and a randomized stream against a model.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // N=8, K=1 instance
  logic        iv1 = 1'b0, ir1, s1 = 1'b0, ov1, or1 = 1'b0, busy1;
  logic [7:0]  a1 = '0, b1 = '0;
  logic [15:0] p1;

  // N=8, K=4 instance
  logic        iv4 = 1'b0, ir4, s4 = 1'b0, ov4, or4 = 1'b0, busy4;
  logic [7:0]  a4 = '0, b4 = '0;
  logic [15:0] p4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.N(8), .K(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .is_signed(s1),
    .data_a(a1), .data_b(b1), .out_valid(ov1), .out_ready(or1),
    .p_out(p1), .busy(busy1)
  );

  seq_multiplier #(.N(8), .K(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .is_signed(s4),
    .data_a(a4), .data_b(b4), .out_valid(ov4), .out_ready(or4),
    .p_out(p4), .busy(busy4)
  );

  // Reference: exact product of the operands as integers, kept in 16 bits
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
    int ai, bi, pr;
    ai = s ? int'($signed(a)) : int'(a);
    bi = s ? int'($signed(b)) : int'(b);
    pr = ai * bi;
    return pr[15:0];
  endfunction

  // Offer one pair to the K=1 instance, scramble inputs after acceptance,
  // and count edges until out_valid (bounded).
  task automatic run_op1(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output int lat, output bit busy_ok);
    int w;
    @(negedge clk);
    a1 = a; b1 = b; s1 = s; iv1 = 1'b1;
    w = 0;
    while (!ir1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk); #1;
    iv1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); s1 = ~s;
    lat = 0;
    busy_ok = 1'b1;
    while (!ov1 && lat < 40) begin
      if (!busy1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume1();
    @(negedge clk);
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (ov1 !== 1'b0 || busy1 !== 1'b0 || ir1 !== 1'b1 || p1 !== 16'h0) begin
      bad++;
      $display("FAIL reset_k1: ov=%b busy=%b ir=%b p=%h required ov=0 busy=0 ir=1 p=0000",
               ov1, busy1, ir1, p1);
    end
    total++;
    if (ov4 !== 1'b0 || busy4 !== 1'b0 || ir4 !== 1'b1 || p4 !== 16'h0) begin
      bad++;
      $display("FAIL reset_k4: ov=%b busy=%b ir=%b p=%h required ov=0 busy=0 ir=1 p=0000",
               ov4, busy4, ir4, p4);
    end
    // First acceptance at the first edge after release
    @(negedge clk);
    rst = 1'b0;
    a1 = 8'd3; b1 = 8'd5; s1 = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    total++;
    if (busy1 !== 1'b1) begin
      bad++;
      $display("FAIL first_accept: busy=%b required 1", busy1);
    end
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (ov1 !== 1'b1 || p1 !== 16'd15) begin
      bad++;
      $display("FAIL first_product: ov=%b p=%h required ov=1 p=000f", ov1, p1);
    end
    consume1();
    $display("test_reset: done");
  endtask

  task automatic test_unsigned_max();
    int lat;
    bit bok;
    run_op1(8'd255, 8'd255, 1'b0, lat, bok);
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL latency_255x255: got %0d edges required 8", lat);
    end
    total++;
    if (!bok) begin
      bad++;
      $display("FAIL busy_255x255: busy dropped=1 required 0");
    end
    total++;
    if (p1 !== 16'hFE01) begin
      bad++;
      $display("FAIL prod_255x255: got %h required fe01", p1);
    end
    consume1();
    $display("test_unsigned_max: 255x255 p=%h lat=%0d", p1, lat);
  endtask

  task automatic test_signed();
    logic [7:0]  ta [3];
    logic [7:0]  tb [3];
    logic        ts [3];
    logic [15:0] te [3];
    int lat;
    bit bok;
    ta = '{8'h80, 8'hFF, 8'h80};
    tb = '{8'h80, 8'h7F, 8'h02};
    ts = '{1'b1, 1'b1, 1'b0};
    te = '{16'h4000, 16'hFF81, 16'h0100};
    for (int i = 0; i < 3; i++) begin
      run_op1(ta[i], tb[i], ts[i], lat, bok);
      total++;
      if (p1 !== te[i] || lat !== 8) begin
        bad++;
        $display("FAIL signed_case%0d: p=%h lat=%0d required p=%h lat=8", i, p1, lat, te[i]);
      end
      $display("test_signed: a=%h b=%h s=%b p=%h", ta[i], tb[i], ts[i], p1);
      consume1();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit bok;
    logic [15:0] held;
    run_op1(8'd7, 8'd9, 1'b0, lat, bok);
    held = p1;
    total++;
    if (held !== 16'd63) begin
      bad++;
      $display("FAIL bp_product: got %h required 003f", held);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (ov1 !== 1'b1 || ir1 !== 1'b0 || p1 !== 16'd63) begin
        bad++;
        $display("FAIL bp_hold%0d: ov=%b ir=%b p=%h required ov=1 ir=0 p=003f", i, ov1, ir1, p1);
      end
    end
    @(negedge clk);
    or1 = 1'b1;
    iv1 = 1'b1; a1 = 8'd1; b1 = 8'd1; s1 = 1'b0;
    total++;
    if (ir1 !== 1'b0) begin
      bad++;
      $display("FAIL bp_turnaround: ir=%b required 0", ir1);
    end
    @(posedge clk); #1;
    or1 = 1'b0;
    iv1 = 1'b0;
    total++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0 || busy1 !== 1'b0 || p1 !== 16'd63) begin
      bad++;
      $display("FAIL bp_release: ir=%b ov=%b busy=%b p=%h required ir=1 ov=0 busy=0 p=003f",
               ir1, ov1, busy1, p1);
    end
    $display("test_backpressure: held p=%h for 5 cycles", held);
  endtask

  task automatic test_reset_mid();
    int lat;
    bit bok;
    @(negedge clk);
    a1 = 8'd100; b1 = 8'd77; s1 = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (ov1 !== 1'b0 || busy1 !== 1'b0 || p1 !== 16'h0 || ir1 !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: ov=%b busy=%b p=%h ir=%b required ov=0 busy=0 p=0000 ir=1",
               ov1, busy1, p1, ir1);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op1(8'd12, 8'd13, 1'b0, lat, bok);
    total++;
    if (p1 !== 16'd156 || lat !== 8) begin
      bad++;
      $display("FAIL after_reset_12x13: p=%h lat=%0d required p=009c lat=8", p1, lat);
    end
    consume1();
    $display("test_reset_mid: 12x13 p=%h lat=%0d", p1, lat);
  endtask

  task automatic test_k4();
    int lat;
    logic [7:0] ra, rb;
    logic rs;
    logic [15:0] exp;
    for (int n = 0; n < 4; n++) begin
      if (n == 0) begin
        ra = 8'd200; rb = 8'd3; rs = 1'b0;
      end else begin
        ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      end
      exp = ref_mul(ra, rb, rs);
      @(negedge clk);
      a4 = ra; b4 = rb; s4 = rs; iv4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0; a4 = 8'h00; b4 = 8'($urandom); s4 = ~rs;
      lat = 0;
      while (!ov4 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      total++;
      if (p4 !== exp || lat !== 2) begin
        bad++;
        $display("FAIL k4_case%0d: p=%h lat=%0d required p=%h lat=2", n, p4, lat, exp);
      end
      $display("test_k4: a=%h b=%h s=%b p=%h lat=%0d", ra, rb, rs, p4, lat);
      @(negedge clk);
      or4 = 1'b1;
      @(posedge clk); #1;
      or4 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic [15:0] e;
    int sent, got, cyc;
    bit acc, fire;
    sent = 0; got = 0; cyc = 0;
    while (got < 50 && cyc < 5000) begin
      @(negedge clk);
      if (!iv1 && sent < 50 && $urandom_range(0, 3) != 0) begin
        a1 = 8'($urandom); b1 = 8'($urandom); s1 = 1'($urandom); iv1 = 1'b1;
      end
      or1 = 1'($urandom_range(0, 1));
      #1;
      acc  = iv1 && ir1;
      fire = ov1 && or1;
      if (fire) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stream_extra: p=%h required no output", p1);
        end else begin
          e = exp_q.pop_front();
          if (p1 !== e) begin
            bad++;
            $display("FAIL stream_prod%0d: got %h required %h", got, p1, e);
          end else begin
            $display("stream %0d: p=%h", got, p1);
          end
        end
        got++;
      end
      if (acc) begin
        exp_q.push_back(ref_mul(a1, b1, s1));
        sent++;
      end
      @(posedge clk); #1;
      if (acc) iv1 = 1'b0;
      cyc++;
    end
    or1 = 1'b0;
    iv1 = 1'b0;
    total++;
    if (got != 50 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL stream_count: received %0d pending %0d required 50 and 0",
               got, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_k4();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_multiplier
